multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mc_decode.sv | 39 +++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/funct constants, ALU operation codes and datapath select values.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALUOP_IMM lets the ALU decoder pick OR or LUI from the opcode.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_IMM  = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    logic       is_jal;
    logic       is_jr;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps op/func to an instruction class
// plus the jal/jr qualifiers the JUMP state needs.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    dec_o = '{cls: CLS_ILLEGAL, is_jal: 1'b0, is_jr: 1'b0};
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADDU, FN_SUBU: dec_o.cls = CLS_RTYPE;
          FN_NOP:           dec_o.cls = CLS_NOP;
          FN_JR: begin
            dec_o.cls   = CLS_JUMP;
            dec_o.is_jr = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: dec_o.cls = CLS_ITYPE;
      OP_LW:          dec_o.cls = CLS_LOAD;
      OP_SW:          dec_o.cls = CLS_STORE;
      OP_BEQ:         dec_o.cls = CLS_BRANCH;
      OP_J:           dec_o.cls = CLS_JUMP;
      OP_JAL: begin
        dec_o.cls    = CLS_JUMP;
        dec_o.is_jal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with a memory-wait timeout (sticky bus_err).
// Build option: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown instructions into HALT.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       memread,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       extop,
  output logic       jal,
  output logic       jr,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       halt,
  output logic       bus_err
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = HALT;
`else
  localparam state_e ILLEGAL_NEXT = FETCH;
`endif

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  dec_t              dec;
  logic              waiting;
  logic              timeout;

  mc_decode u_decode (
    .op_i  (op),
    .func_i(func),
    .dec_o (dec)
  );

  assign waiting = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready;
  // The WAIT_MAX-th consecutive idle cycle times out; mem_ready in that cycle completes instead.
  assign timeout = waiting && (wait_q == WAIT_W'(WAIT_MAX - 1));

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    bus_err_d = bus_err_q;
    if (waiting) wait_d = wait_q + 1'b1;
    case (state_q)
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (dec.cls)
          CLS_RTYPE:          state_d = EXEC_R;
          CLS_ITYPE:          state_d = EXEC_I;
          CLS_LOAD, CLS_STORE: state_d = MEM_ADDR;
          CLS_BRANCH:         state_d = BRANCH;
          CLS_JUMP:           state_d = JUMP;
          CLS_ILLEGAL:        state_d = ILLEGAL_NEXT;
          default:            state_d = FETCH;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (dec.cls == CLS_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_d = WB_MEM;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
    if (timeout) begin
      state_d   = HALT;
      bus_err_d = 1'b1;
      wait_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    extop    = 1'b0;
    jal      = 1'b0;
    jr       = 1'b0;
    alusrcb  = SRCB_REG;
    aluop    = ALUOP_ADD;
    pcsrc    = PC_SEQ;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          alusrcb = SRCB_FOUR;
        end
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the registers are read.
        alusrcb = SRCB_BOFF;
        extop   = 1'b1;
      end
      EXEC_R: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNC;
      end
      EXEC_I: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_IMM;
      end
      MEM_ADDR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        extop   = 1'b1;
      end
      MEM_RD: memread  = 1'b1;
      MEM_WR: memwrite = mem_ready;
      WB_R: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      WB_I: regwrite = 1'b1;
      WB_MEM: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcwrite = zero;
        pcsrc   = PC_BRANCH;
      end
      JUMP: begin
        pcwrite = 1'b1;
        if (dec.is_jr) begin
          jr    = 1'b1;
          pcsrc = PC_REG;
        end else begin
          pcsrc = PC_JUMP;
        end
        if (dec.is_jal) begin
          jal      = 1'b1;
          regwrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign halt    = (state_q == HALT);
  assign bus_err = bus_err_q;

endmodule
